// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared types, limits and round-robin pick helper for key_event_scheduler
package key_evt_pkg;
  localparam int MAX_N = 16;
  localparam int MAX_IW = 4;
  localparam int DCNT_W_DEF = 8;
  localparam int DROP_SAT_DEF = 2 ** DCNT_W_DEF - 1;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  typedef struct packed {
    logic found;
    logic [MAX_IW-1:0] idx;
  } rr_t;
  function automatic rr_t rr_pick(logic [MAX_N-1:0] req, logic [MAX_IW-1:0] ptr, int n);
    rr_t r;
    int k;
    r = '0;
    for (int o = MAX_N - 1; o >= 0; o--) begin
      if (o < n) begin
        k = int'(ptr) + o;
        if (k >= n) k -= n;
        if (req[k]) begin
          r.found = 1'b1;
          r.idx = k[MAX_IW-1:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/key_event_scheduler_if.sv
// key_evt_if: valid/ready event port between the scheduler and its consumer
interface key_evt_if #(parameter int CODE_W = 2) ();
  logic evt_valid;
  logic evt_ready;
  logic [CODE_W-1:0] evt_code;
  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts at ptr and wraps N-1 -> 0
module rr_arbiter
  import key_evt_pkg::*;
#(
  parameter int N = 4,
  parameter int CODE_W = 2
) (
  input  logic [N-1:0]      req,
  input  logic [CODE_W-1:0] ptr,
  output logic              gnt_valid,
  output logic [CODE_W-1:0] gnt_idx
);
  rr_t pick;
  // first requester at or after ptr, cyclically
  always_comb begin
    pick = rr_pick(MAX_N'(req), MAX_IW'(ptr), N);
  end
  assign gnt_valid = pick.found;
  assign gnt_idx = CODE_W'(pick.idx);
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: queues debounced key pulses and issues them round-robin over valid/ready; DROP_CNT_EN adds drop_cnt
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int N = 4,
  parameter int CODE_W = 2,
  parameter int DCNT_W = DCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      key_pulse,
  key_evt_if.master         evt,
  output logic              evt_drop,
`ifdef DROP_CNT_EN
  output logic [DCNT_W-1:0] drop_cnt,
`endif
  output logic [N-1:0]      pending
);
  state_t state_q, state_d;
  logic [N-1:0] pending_q, pending_d, load_mask, drop_vec;
  logic [CODE_W-1:0] code_q, code_d, ptr_q, ptr_d, gnt_idx;
  logic drop_q, drop_d, gnt_valid, load;

  rr_arbiter #(.N(N), .CODE_W(CODE_W)) u_arb (
    .req(pending_q),
    .ptr(ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );

  // load on idle, or on a handshake in HOLD; this cycle's pulses only reach the arbiter next cycle
  always_comb begin
    load = gnt_valid && (state_q == IDLE || evt.evt_ready);
    load_mask = load ? {{(N-1){1'b0}}, 1'b1} << gnt_idx : '0;
    drop_vec = key_pulse & pending_q & ~load_mask;
    pending_d = (pending_q & ~load_mask) | key_pulse;
    drop_d = |drop_vec;
    state_d = (load || (state_q == HOLD && !evt.evt_ready)) ? HOLD : IDLE;
    code_d = load ? gnt_idx : code_q;
    ptr_d = load ? (gnt_idx == CODE_W'(N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end

  // scheduler state, pending flags, output register and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      code_q <= '0;
      ptr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      code_q <= code_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
    end
  end

`ifdef DROP_CNT_EN
  localparam logic [DCNT_W-1:0] DROP_SAT = '1;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic [DCNT_W+4:0] sum;
  // add the number of keys dropped this cycle, saturating at all-ones
  always_comb begin
    sum = (DCNT_W + 5)'(cnt_q);
    for (int i = 0; i < N; i++) sum = sum + (DCNT_W + 5)'(drop_vec[i]);
    cnt_d = (sum > (DCNT_W + 5)'(DROP_SAT)) ? DROP_SAT : sum[DCNT_W-1:0];
  end
  // drop counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign drop_cnt = cnt_q;
`endif

  assign evt.evt_valid = (state_q == HOLD);
  assign evt.evt_code = code_q;
  assign evt_drop = drop_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed checks of key_event_scheduler (N=4, CODE_W=2, DCNT_W=2)
module tb_key_event_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] kp = '0;
  logic evt_drop;
  logic [3:0] pending;
`ifdef DROP_CNT_EN
  logic [1:0] drop_cnt;
`endif
  int checks = 0;
  int errors = 0;

  key_evt_if #(.CODE_W(2)) evt ();

  key_event_scheduler #(.N(4), .CODE_W(2), .DCNT_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_pulse(kp),
    .evt(evt),
    .evt_drop(evt_drop),
`ifdef DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic v, input logic [1:0] c, input logic [3:0] p, input logic d);
    chk({tag, ".valid"}, 32'(evt.evt_valid), 32'(v));
    if (v) chk({tag, ".code"}, 32'(evt.evt_code), 32'(c));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
    chk({tag, ".drop"}, 32'(evt_drop), 32'(d));
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kp = '0;
    evt.evt_ready = 1'b0;
    nx();
    nx();
    rst_n = 1'b1;
  endtask

  initial begin
    evt.evt_ready = 1'b0;
    do_reset();
    out("rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("rst.code", 32'(evt.evt_code), 32'd0);
`ifdef DROP_CNT_EN
    chk("rst.cnt", 32'(drop_cnt), 32'd0);
`endif
    // single press
    kp = 4'b0001; evt.evt_ready = 1'b1;
    nx(); kp = '0;
    out("single.k", 1'b0, 2'd0, 4'b0001, 1'b0);
    nx(); out("single.k1", 1'b1, 2'd0, 4'b0000, 1'b0);
    nx(); out("single.idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    // round robin from a fresh pointer
    do_reset();
    evt.evt_ready = 1'b1; kp = 4'b1111;
    nx(); kp = '0;
    out("rr.pend", 1'b0, 2'd0, 4'b1111, 1'b0);
    nx(); out("rr.c0", 1'b1, 2'd0, 4'b1110, 1'b0);
    nx(); out("rr.c1", 1'b1, 2'd1, 4'b1100, 1'b0);
    nx(); out("rr.c2", 1'b1, 2'd2, 4'b1000, 1'b0);
    nx(); out("rr.c3", 1'b1, 2'd3, 4'b0000, 1'b0);
    kp = 4'b0011;
    nx(); kp = '0;
    out("rr.idle", 1'b0, 2'd0, 4'b0011, 1'b0);
    nx(); out("rr.wrap0", 1'b1, 2'd0, 4'b0010, 1'b0);
    nx(); out("rr.wrap1", 1'b1, 2'd1, 4'b0000, 1'b0);
    nx(); out("rr.end", 1'b0, 2'd0, 4'b0000, 1'b0);
    // backpressure, then back-to-back issue
    do_reset();
    kp = 4'b0100;
    nx(); kp = 4'b0010;
    nx(); kp = '0;
    out("bp.load", 1'b1, 2'd2, 4'b0010, 1'b0);
    nx(); out("bp.hold", 1'b1, 2'd2, 4'b0010, 1'b0);
    evt.evt_ready = 1'b1;
    nx(); out("bp.b2b", 1'b1, 2'd1, 4'b0000, 1'b0);
    nx(); out("bp.idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    // async reset while holding code 2 with key 1 pending
    do_reset();
    kp = 4'b0100;
    nx(); kp = 4'b0010;
    nx(); kp = '0;
    out("ar.pre", 1'b1, 2'd2, 4'b0010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(evt.evt_valid), 32'd0);
    chk("ar.pending", 32'(pending), 32'd0);
    chk("ar.ptr", 32'(dut.ptr_q), 32'd0);
    nx(); rst_n = 1'b1;
    evt.evt_ready = 1'b1; kp = 4'b0010;
    nx(); kp = '0;
    nx(); out("ar.key1", 1'b1, 2'd1, 4'b0000, 1'b0);
    // drop while pending and held
    do_reset();
    kp = 4'b1000;
    nx(); kp = '0;
    out("drop.p", 1'b0, 2'd0, 4'b1000, 1'b0);
    nx(); kp = 4'b1000;
    out("drop.load", 1'b1, 2'd3, 4'b0000, 1'b0);
    nx(); kp = 4'b1000;
    out("drop.repend", 1'b1, 2'd3, 4'b1000, 1'b0);
    nx(); kp = '0;
    out("drop.pulse", 1'b1, 2'd3, 4'b1000, 1'b1);
`ifdef DROP_CNT_EN
    chk("drop.cnt1", 32'(drop_cnt), 32'd1);
`endif
    nx(); out("drop.once", 1'b1, 2'd3, 4'b1000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      kp = 4'b1000;
      nx(); kp = '0;
      nx();
    end
    out("drop.more", 1'b1, 2'd3, 4'b1000, 1'b0);
`ifdef DROP_CNT_EN
    chk("drop.sat", 32'(drop_cnt), 32'd3);
`endif
    // pulse on a key in the same cycle it is loaded
    do_reset();
    evt.evt_ready = 1'b1; kp = 4'b0100;
    nx();
    nx(); kp = '0;
    out("sim.first", 1'b1, 2'd2, 4'b0100, 1'b0);
    nx(); out("sim.second", 1'b1, 2'd2, 4'b0000, 1'b0);
    nx(); out("sim.idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
Sits downstream of the N-key debouncer, at the same 12 MHz clock. Captures each one-cycle key_pulse[i] into a per-key pending flag. Shares a single event output port among the N keys using round-robin arbitration. Presents one encoded key code at a time to a consumer over a valid/ready handshake, and flags events lost because a key was already pending.

Parameters:
N, 4, number of debounced keys (2..16)
CODE_W, 2, width of the key index; must satisfy 2**CODE_W >= N
DCNT_W, 8, width of the drop counter (used only with the optional feature)

Ports:
clk  input  1  system clock (12 MHz)
rst_n  input  1  asynchronous active-low reset
key_pulse  input  N  one-cycle press pulses from the debouncer, active high
evt_ready  input  1  consumer can accept an event this cycle
evt_valid  output  1  evt_code holds a valid event
evt_code  output  CODE_W  index of the pressed key
evt_drop  output  1  one-cycle pulse: a press was lost
pending  output  N  per-key pending flags, for status and debug
drop_cnt  output  DCNT_W  saturating count of lost presses; present only with DROP_CNT_EN

Behaviour:
- Reset is asynchronous on rst_n low. All registers clear: pending=0, evt_valid=0, evt_code=0, evt_drop=0, rr_ptr=0, state=IDLE, drop_cnt=0.
- Reset mid-handshake discards the held event and all pending flags.
- Pending set: key_pulse[i] sampled high at edge k sets pending[i] after edge k.
- Pending clear: pending[i] clears on the edge where key i is loaded into the output register.
- Simultaneous set and clear on the same key in the same cycle: pending[i] stays 1. The new press is queued, not dropped.
- Drop: key_pulse[i]=1 while pending[i]=1 and key i is not being loaded this cycle.
  - pending stays 1.
  - evt_drop=1 for exactly one cycle after that edge.
  - Several keys dropping in the same cycle still give a single evt_drop pulse; drop_cnt adds the number of dropped keys.
- Arbitration: round-robin over pending.
  - Search starts at rr_ptr and wraps from N-1 to 0.
  - On a load of key g: rr_ptr <= (g+1) mod N.
  - After reset, key 0 has highest priority.
- FSM, two states:
  - IDLE (evt_valid=0): if any pending is set, load the winner into evt_code, set evt_valid=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD (evt_valid=1): evt_code is held stable while evt_ready=0.
  - HOLD with evt_valid and evt_ready high (handshake): if any pending is set at that cycle, load the next winner on the same edge and stay in HOLD (back-to-back, no bubble). Otherwise clear evt_valid and go to IDLE.
- Latency:
  - Press sampled at edge k gives evt_valid=1 after edge k+1 when the scheduler is idle.
  - Sustained throughput is one event per cycle while evt_ready=1.
- A key whose code sits in the output register may become pending again. Each key therefore holds at most 2 events in flight: one in the output register, one pending.
- A pulse present in the same cycle as the IDLE load decision is not visible to that decision; it is seen one cycle later.
- key_pulse bits with index >= N do not exist. evt_code never exceeds N-1.

Optional Feature:
DROP_CNT_EN
- Defined:
  - The drop_cnt port and register exist.
  - Increment by the number of keys dropped in the cycle.
  - Saturate at 2**DCNT_W-1; no wrap.
  - Cleared only by reset.
- Undefined:
  - The port and register are absent.
  - evt_drop behaviour is unchanged.

Decomposition:
- Package key_evt_pkg holds:
  - the state enum {IDLE, HOLD};
  - function rr_pick(pending, ptr), returning found plus index;
  - a localparam for the saturation limit.
- One sub-module, rr_arbiter (N, CODE_W): combinational round-robin picker. Inputs: req[N-1:0], ptr. Outputs: gnt_valid, gnt_idx.
- The top level holds the pending flags, FSM, pointer, output register and drop logic.

Test Plan:
1. Reset: assert rst_n=0 mid-HOLD with evt_code=2 → evt_valid=0, pending=0 and rr_ptr=0 immediately, not waiting for a clock edge. After release, pulse key 1 → evt_code=1.
2. Single press: key_pulse=4'b0001 for one cycle at edge k, evt_ready=1 → evt_valid=1 with evt_code=0 after edge k+1. Valid lasts one cycle, then the scheduler returns to IDLE.
3. Round-robin: key_pulse=4'b1111 in one cycle, evt_ready=1 → codes 0,1,2,3 on four consecutive cycles. Then pulse 4'b0011 → code 0 first, because rr_ptr wrapped to 0.
4. Backpressure: evt_ready=0, pulse 4'b0100 then 4'b0010 → evt_code=2 held stable. pending=4'b0010. Raise evt_ready → code 2, then code 1, back-to-back.
5. Drop: evt_ready=0, pulse key 3 twice while it is pending → one evt_drop pulse and pending[3] stays 1. With DROP_CNT_EN, drop_cnt=1. With DCNT_W=2, 5 drops → drop_cnt=3.
6. Simultaneous: key 2 is pending and being loaded, and key_pulse[2]=1 in that same cycle → no evt_drop, pending[2]=1, code 2 issued twice.
